// File: rtl/fp_cmp_pkg.sv
// Shared op encodings, stage-1 decode record and IEEE-style field helpers for
// the floating-point compare pipeline.
package fp_cmp_pkg;

  localparam logic [1:0] OP_CMP = 2'b00;
  localparam logic [1:0] OP_MIN = 2'b01;
  localparam logic [1:0] OP_MAX = 2'b10;

  typedef struct packed {
    logic sign_a;
    logic sign_b;
    logic exp_lt;
    logic exp_eq;
    logic frac_lt;
    logic frac_eq;
    logic zero_a;
    logic zero_b;
    logic nan_a;
    logic nan_b;
  } fp_dec_t;

  // Helpers work on a 64-bit container so any format up to 64 bits fits.
  function automatic logic fp_sign(input logic [63:0] x, input int w);
    return x[w-1];
  endfunction

  function automatic logic [63:0] fp_exp(input logic [63:0] x, input int exp_w, input int frac_w);
    return (x >> frac_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_frac(input logic [63:0] x, input int frac_w);
    return x & ((64'd1 << frac_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int frac_w);
    logic [63:0] e_ones;
    e_ones = (64'd1 << exp_w) - 64'd1;
    return (e_ones << frac_w) | (64'd1 << (frac_w - 1));
  endfunction

endpackage

// File: rtl/fp_cmp_core.sv
// Combinational classify/compare: a decode path feeding stage 1 and a resolve
// path turning the registered decode into flags and MIN/MAX result.
module fp_cmp_core
  import fp_cmp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  localparam int W     = 1 + EXP_W + FRAC_W
) (
  input  logic [W-1:0] dec_a_i,
  input  logic [W-1:0] dec_b_i,
  output fp_dec_t      dec_o,
  input  logic [W-1:0] res_a_i,
  input  logic [W-1:0] res_b_i,
  input  logic [1:0]   res_op_i,
  input  fp_dec_t      res_dec_i,
  output logic         lt_o,
  output logic         eq_o,
  output logic         gt_o,
  output logic         unord_o,
  output logic [W-1:0] res_o
);

  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic              mag_lt, mag_eq, both_zero;

  assign exp_a  = EXP_W'(fp_exp(64'(dec_a_i), EXP_W, FRAC_W));
  assign exp_b  = EXP_W'(fp_exp(64'(dec_b_i), EXP_W, FRAC_W));
  assign frac_a = FRAC_W'(fp_frac(64'(dec_a_i), FRAC_W));
  assign frac_b = FRAC_W'(fp_frac(64'(dec_b_i), FRAC_W));

  always_comb begin
    dec_o         = '0;
    dec_o.sign_a  = fp_sign(64'(dec_a_i), W);
    dec_o.sign_b  = fp_sign(64'(dec_b_i), W);
    dec_o.exp_lt  = exp_a < exp_b;
    dec_o.exp_eq  = exp_a == exp_b;
    dec_o.frac_lt = frac_a < frac_b;
    dec_o.frac_eq = frac_a == frac_b;
    dec_o.zero_a  = (exp_a == '0) && (frac_a == '0);
    dec_o.zero_b  = (exp_b == '0) && (frac_b == '0);
`ifdef FP_CMP_NAN_EN
    dec_o.nan_a   = (&exp_a) && (|frac_a);
    dec_o.nan_b   = (&exp_b) && (|frac_b);
`endif
  end

  assign mag_lt    = res_dec_i.exp_lt || (res_dec_i.exp_eq && res_dec_i.frac_lt);
  assign mag_eq    = res_dec_i.exp_eq && res_dec_i.frac_eq;
  assign both_zero = res_dec_i.zero_a && res_dec_i.zero_b;

  always_comb begin
    lt_o    = 1'b0;
    eq_o    = 1'b0;
    gt_o    = 1'b0;
    unord_o = 1'b0;
    res_o   = res_a_i;
    if (both_zero)                              eq_o = 1'b1;
    else if (res_dec_i.sign_a != res_dec_i.sign_b) begin
      if (res_dec_i.sign_a) lt_o = 1'b1;
      else                  gt_o = 1'b1;
    end
    else if (mag_eq)                            eq_o = 1'b1;
    // Among negatives the magnitude order flips.
    else if (mag_lt ^ res_dec_i.sign_a)         lt_o = 1'b1;
    else                                        gt_o = 1'b1;

    case (res_op_i)
      OP_MIN: if (gt_o || (eq_o && both_zero && !res_dec_i.sign_a)) res_o = res_b_i;
      OP_MAX: if (lt_o || (eq_o && both_zero && res_dec_i.sign_a))  res_o = res_b_i;
      default: res_o = res_a_i;
    endcase

`ifdef FP_CMP_NAN_EN
    if (res_dec_i.nan_a || res_dec_i.nan_b) begin
      lt_o    = 1'b0;
      eq_o    = 1'b0;
      gt_o    = 1'b0;
      unord_o = 1'b1;
      res_o   = res_a_i;
      if (res_op_i == OP_MIN || res_op_i == OP_MAX) begin
        if (res_dec_i.nan_a && res_dec_i.nan_b) res_o = W'(fp_qnan(EXP_W, FRAC_W));
        else if (res_dec_i.nan_a)               res_o = res_b_i;
        else                                    res_o = res_a_i;
      end
    end
`endif
  end

`ifndef FP_CMP_NAN_EN
  logic unused_nan;
  assign unused_nan = res_dec_i.nan_a ^ res_dec_i.nan_b;
`endif

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage valid/ready floating-point CMP/MIN/MAX pipeline.
// Define FP_CMP_NAN_EN to classify NaN operands as unordered.
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4,
  localparam int W     = 1 + EXP_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lt,
  output logic             out_eq,
  output logic             out_gt,
  output logic             out_unord,
  output logic [W-1:0]     out_res,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid_q;
  logic [W-1:0]     s1_a_q, s1_b_q;
  logic [1:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;
  fp_dec_t          s1_dec_q, s1_dec_d;

  logic             out_valid_q, lt_q, eq_q, gt_q, unord_q;
  logic             lt_d, eq_d, gt_d, unord_d;
  logic [W-1:0]     res_q, res_d;
  logic [TAG_W-1:0] tag_q;

  logic s1_adv, s2_adv;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  fp_cmp_core #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_core (
    .dec_a_i   (in_a),
    .dec_b_i   (in_b),
    .dec_o     (s1_dec_d),
    .res_a_i   (s1_a_q),
    .res_b_i   (s1_b_q),
    .res_op_i  (s1_op_q),
    .res_dec_i (s1_dec_q),
    .lt_o      (lt_d),
    .eq_o      (eq_d),
    .gt_o      (gt_d),
    .unord_o   (unord_d),
    .res_o     (res_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      s1_dec_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_op_q  <= in_op;
        s1_tag_q <= in_tag;
        s1_dec_q <= s1_dec_d;
      end
    end
  end

  // Output data only changes when a new result moves in, so it holds under stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      unord_q     <= 1'b0;
      res_q       <= '0;
      tag_q       <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        lt_q    <= lt_d;
        eq_q    <= eq_d;
        gt_q    <= gt_d;
        unord_q <= unord_d;
        res_q   <= res_d;
        tag_q   <= s1_tag_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_lt    = lt_q;
  assign out_eq    = eq_q;
  assign out_gt    = gt_q;
  assign out_unord = unord_q;
  assign out_res   = res_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Scoreboard bench for fp_compare_pipe (single precision); honours FP_CMP_NAN_EN.
module tb_fp_compare_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic        out_lt, out_eq, out_gt, out_unord;
  logic [31:0] out_res;
  logic [3:0]  out_tag;

  always #5 clk = ~clk;

  fp_compare_pipe #(.EXP_W(8), .FRAC_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lt(out_lt), .out_eq(out_eq), .out_gt(out_gt), .out_unord(out_unord),
    .out_res(out_res), .out_tag(out_tag)
  );

  typedef struct {
    logic [3:0]  flags;   // {lt, eq, gt, unord}
    logic [31:0] res;
    logic [3:0]  tag;
    int          id;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge when valid && ready here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {60'd0, out_tag}, 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check($sformatf("vec%0d", e.id),
                {20'd0, out_lt, out_eq, out_gt, out_unord, out_res, out_tag},
                {20'd0, e.flags, e.res, e.tag});
          if (e.chk_lat) check($sformatf("latency%0d", e.id), 64'(cyc - e.acc_cyc), 64'd2);
          $display("[TB] out id=%0d tag=%0h res=%08h flags=%b%b%b%b", e.id, out_tag, out_res,
                   out_lt, out_eq, out_gt, out_unord);
          n_out++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [3:0] tag,
                      input logic [3:0] flags, input logic [31:0] res, input bit lat);
    exp_t e;
    bit   acc = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.flags = flags; e.res = res; e.tag = tag; e.id = id;
        e.acc_cyc = cyc; e.chk_lat = lat;
        sb.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!acc) check($sformatf("accept_timeout%0d", id), 64'd0, 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  localparam logic [3:0] LT = 4'b1000, EQ = 4'b0100, GT = 4'b0010, UN = 4'b0001;

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_flags", 64'({out_lt, out_eq, out_gt, out_unord}), 64'd0);
    check("rst_res", 64'(out_res), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;

    send(1,  32'h3F800000, 32'h40000000, 2'b00, 4'h1, LT, 32'h3F800000, 1'b1);
    send(2,  32'hBF800000, 32'hC0000000, 2'b01, 4'h2, GT, 32'hC0000000, 1'b0);
    send(3,  32'h80000000, 32'h00000000, 2'b10, 4'h3, EQ, 32'h00000000, 1'b0);
`ifdef FP_CMP_NAN_EN
    send(4,  32'h7FC00000, 32'h3F800000, 2'b01, 4'h4, UN, 32'h3F800000, 1'b0);
    send(11, 32'h7FC00000, 32'hFFC00001, 2'b01, 4'hB, UN, 32'h7FC00000, 1'b0);
`else
    send(4,  32'h7FC00000, 32'h3F800000, 2'b01, 4'h4, GT, 32'h3F800000, 1'b0);
    send(11, 32'h7FC00000, 32'hFFC00001, 2'b01, 4'hB, GT, 32'hFFC00001, 1'b0);
`endif
    send(5,  32'h00000000, 32'h80000000, 2'b01, 4'h5, EQ, 32'h80000000, 1'b0);
    send(6,  32'h40400000, 32'h40400000, 2'b10, 4'h6, EQ, 32'h40400000, 1'b0);
    send(7,  32'hC0000000, 32'h3F800000, 2'b11, 4'h7, LT, 32'hC0000000, 1'b0);
    send(8,  32'hC0400000, 32'hC0000000, 2'b10, 4'h8, LT, 32'hC0000000, 1'b0);
    send(9,  32'h3F800001, 32'h3F800000, 2'b00, 4'h9, GT, 32'h3F800001, 1'b0);
    send(10, 32'h7F800000, 32'h7F7FFFFF, 2'b10, 4'hA, GT, 32'h7F800000, 1'b0);
    send(12, 32'h3F800000, 32'h00000000, 2'b00, 4'hC, GT, 32'h3F800000, 1'b1);
    idle();
    drain("drain_directed");

    // Back-to-back stream with a three-cycle output stall in the middle.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(20 + i, 32'h3F800000 + 32'(i), 32'h3F800004, 2'b00, 4'(i),
               (i < 4) ? LT : (i == 4) ? EQ : GT, 32'h3F800000 + 32'(i), 1'b0);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check($sformatf("stall_in_ready%0d", k), 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_stream");
    check("stream_count", 64'(n_out - base), 64'd8);

    // Reset with two operations held in flight.
    out_ready = 1'b0;
    send(30, 32'h3F800000, 32'h40000000, 2'b00, 4'hE, LT, 32'h3F800000, 1'b0);
    send(31, 32'h40000000, 32'h3F800000, 2'b00, 4'hF, GT, 32'h40000000, 1'b0);
    idle();
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("no_stale%0d", k), 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(40, 32'hBF800000, 32'h3F800000, 2'b10, 4'h5, LT, 32'h3F800000, 1'b1);
    idle();
    drain("drain_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_compare_pipe.md
FP_COMPARE_PIPE -- requirements
Module: fp_compare_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter FRAC_W, default 23, fraction field width; operand width W = 1+EXP_W+FRAC_W.
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 SHALL have port in_valid  input  1  operand pair and op present.
REQ-007 SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-008 SHALL have ports in_a and in_b  input  W  operands: sign MSB, then exponent, then fraction.
REQ-009 SHALL have port in_op  input  2  operation: 00 CMP, 01 MIN, 10 MAX, 11 reserved, treated as CMP.
REQ-010 SHALL have port in_tag  input  TAG_W  sideband, returned unmodified.
REQ-011 SHALL have ports out_valid (output 1) and out_ready (input 1), the result handshake.
REQ-012 SHALL have ports out_lt, out_eq, out_gt, out_unord  output  1 each  relation of A to B.
REQ-013 SHALL have ports out_res (output W, MIN/MAX value; equal to A for CMP) and out_tag (output TAG_W).

Function
REQ-014 SHALL accept an operation on a rising edge with in_valid and in_ready both high, and deliver its result on a rising edge with out_valid and out_ready both high.
REQ-015 SHALL use two register stages: s1 holds sign, exponent-compare and fraction-compare decode; s2 holds the final flags and result.
REQ-016 SHALL present out_valid exactly 2 cycles after acceptance when out_ready is held high, sustaining 1 operation per cycle.
REQ-017 SHALL advance s2 when !out_valid || out_ready, advance s1 when !s1_valid || s2 advances, and drive in_ready = s1 advance (combinational; no bubble under back-pressure release).
REQ-018 SHALL hold out_* stable while out_valid && !out_ready, and never drop, duplicate or reorder operations.
REQ-019 SHALL compare in sign-magnitude order: between two negatives, the larger magnitude is less.
REQ-020 SHALL treat +0 and -0 as equal: out_eq=1; MIN returns -0 and MAX returns +0.
REQ-021 SHALL assert exactly one of lt/eq/gt/unord for every result.
REQ-022 SHALL, for MIN/MAX with equal non-zero operands, return in_a.
REQ-023 SHALL treat a simultaneous accept and deliver in the same cycle as legal, with both taking effect.

Reset
REQ-024 SHALL, while rst_n is low on a clock edge, clear s1_valid and out_valid to 0 and the flags, out_res and out_tag to 0; in_ready reads 1 in the first cycle after reset release.
REQ-025 SHALL discard in-flight operations on reset mid-operation and produce no result for them.

Configuration
REQ-026 SHALL, when FP_CMP_NAN_EN is defined, classify NaN (exponent all ones, fraction non-zero) as unordered: if either operand is NaN, out_unord=1 and lt/eq/gt=0.
REQ-027 SHALL, when FP_CMP_NAN_EN is defined, make MIN/MAX with exactly one NaN return the other operand, and with two NaNs return canonical qNaN {0, all ones, 1, zeros}.
REQ-028 SHALL, when FP_CMP_NAN_EN is not defined, compare NaN/Inf patterns as ordinary magnitudes and tie out_unord to 0.

Structure
REQ-029 SHALL define the op encoding localparams, a canonical-qNaN function and the field-extract helpers in package fp_cmp_pkg.
REQ-030 SHALL place the combinational classify/compare logic in sub-module fp_cmp_core, with the stage registers and handshake in fp_compare_pipe.

Verification (EXP_W=8, FRAC_W=23)
REQ-031 SHALL check: CMP A=0x3F800000 (1.0), B=0x40000000 (2.0) -> lt=1 two cycles later.
REQ-032 SHALL check: MIN A=0xBF800000 (-1.0), B=0xC0000000 (-2.0) -> gt=1, out_res=0xC0000000.
REQ-033 SHALL check: MAX A=0x80000000, B=0x00000000 -> eq=1, out_res=0x00000000.
REQ-034 SHALL check: with FP_CMP_NAN_EN, MIN A=0x7FC00000, B=0x3F800000 -> unord=1, out_res=0x3F800000; without the macro -> gt=1, unord=0.
REQ-035 SHALL check: 8 back-to-back ops with out_ready low for 3 cycles mid-stream -> in_ready=0 while full, all 8 tags emerge in order with none lost.
REQ-036 SHALL check: rst_n low for one cycle with 2 ops in flight -> out_valid=0 next cycle and no stale result afterwards.
